// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: load FSM encoding
// and default instruction-memory geometry.
package mips_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int MAX_WORDS  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } load_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles a big-endian 32-bit word from four accepted bytes and pulses
// word_valid for one cycle once the fourth byte has landed.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] byte_cnt;

    // Combinational so the loader can see the word boundary on the same edge.
    assign last_byte = (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= byte_valid && last_byte;
            if (byte_valid) begin
                word     <= {word[23:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory
// and holds the CPU in reset until a good image has been loaded.
//
// state  | meaning
// S_LEN  | waiting for the word-count byte
// S_DATA | receiving data bytes, writing each completed word
// S_CSUM | waiting for the checksum byte
// S_DONE | image loaded and verified, CPU released
// S_ERR  | bad length or checksum, CPU stays held
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int MAX_N = 1 << ADDR_W;

    load_state_t state;
    logic [7:0]  words_left;
    logic [7:0]  csum;
    logic        accept;
    logic        data_accept;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] packed_word;

    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state == S_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (data_accept),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    assign wr_en   = word_valid;
    assign wr_data = packed_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_LEN;
            in_ready   <= 1'b1;
            wr_addr    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            csum       <= 8'd0;
            words_left <= 8'd0;
        end else begin
            // Saturate so a full-memory image leaves wr_addr on the last word.
            if (wr_en && (wr_addr != {ADDR_W{1'b1}}))
                wr_addr <= wr_addr + 1'b1;

            case (state)
                S_LEN: begin
                    if (accept) begin
                        if ((in_data == 8'd0) || (int'(in_data) > MAX_N)) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            words_left <= in_data;
                            state      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_accept) begin
                        csum <= csum ^ in_data;
                        if (last_byte) begin
                            words_left <= words_left - 8'd1;
                            if (words_left == 8'd1)
                                state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        csum     <= 8'd0;
                        wr_addr  <= '0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_ERR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule
